// File: rtl/pipe_stage_skid_reg_pkg.sv
// Shared definitions for the inter-stage pipeline register.
//  - state_t: occupancy of the main/skid slot pair. Bit 0 is main valid, bit 1 is skid valid.
//  - Per-stage payload/control widths and field offsets, so that every stage packs its
//    IN_DATA/IN_CTRL vectors the same way. Offsets count up from bit 0 (LSB field first).
package pipe_stage_skid_reg_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_HALF  = 2'b01,
    ST_FULL  = 2'b11
  } state_t;

  // IF/ID: {pc, instr}
  localparam int IF_ID_DATA_W     = 64;
  localparam int IF_ID_CTRL_W     = 1;
  localparam int IF_ID_INSTR_OFS  = 0;
  localparam int IF_ID_PC_OFS     = 32;

  // ID/EX: {rd, pc, data1, data2, imm}
  localparam int ID_EX_DATA_W     = 133;
  localparam int ID_EX_CTRL_W     = 8;
  localparam int ID_EX_IMM_OFS    = 0;
  localparam int ID_EX_DATA2_OFS  = 32;
  localparam int ID_EX_DATA1_OFS  = 64;
  localparam int ID_EX_PC_OFS     = 96;
  localparam int ID_EX_RD_OFS     = 128;

  // EX/MEM: {rd, pc, alu_result, data2}
  localparam int EX_MEM_DATA_W    = 101;
  localparam int EX_MEM_CTRL_W    = 4;
  localparam int EX_MEM_DATA2_OFS = 0;
  localparam int EX_MEM_ALU_OFS   = 32;
  localparam int EX_MEM_PC_OFS    = 64;
  localparam int EX_MEM_RD_OFS    = 96;

  // MEM/WB: {rd, pc, alu_result, mem_data}
  localparam int MEM_WB_DATA_W    = 101;
  localparam int MEM_WB_CTRL_W    = 3;
  localparam int MEM_WB_MEM_OFS   = 0;
  localparam int MEM_WB_ALU_OFS   = 32;
  localparam int MEM_WB_PC_OFS    = 64;
  localparam int MEM_WB_RD_OFS    = 96;

endpackage

// File: rtl/pipe_stage_skid_reg_slot.sv
// One storage slot of the pipeline register: payload + control + valid bit.
// Ports:
//  clk, rst_n        rising-edge clock, asynchronous active-low reset
//  load              capture d_data/d_ctrl and mark the slot valid
//  clear             mark the slot invalid; control drops to CTRL_BUBBLE, payload is kept
//  d_data, d_ctrl    value to capture on load
//  vld               slot holds a valid entry
//  q_data, q_ctrl    stored payload / control
// clear has priority over load so a flush always wins.
module pipe_stage_skid_reg_slot
  import pipe_stage_skid_reg_pkg::*;
#(
  parameter int                    DATA_WIDTH  = 133,
  parameter int                    CTRL_WIDTH  = 8,
  parameter logic [CTRL_WIDTH-1:0] CTRL_BUBBLE = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic                  clear,
  input  logic [DATA_WIDTH-1:0] d_data,
  input  logic [CTRL_WIDTH-1:0] d_ctrl,
  output logic                  vld,
  output logic [DATA_WIDTH-1:0] q_data,
  output logic [CTRL_WIDTH-1:0] q_ctrl
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld    <= 1'b0;
      q_data <= '0;
      q_ctrl <= CTRL_BUBBLE;
    end else if (clear) begin
      vld    <= 1'b0;
      q_ctrl <= CTRL_BUBBLE;
    end else if (load) begin
      vld    <= 1'b1;
      q_data <= d_data;
      q_ctrl <= d_ctrl;
    end
  end

endmodule

// File: rtl/pipe_stage_skid_reg.sv
// Inter-stage pipeline register with valid/ready handshake and a 2-entry skid buffer.
// Ports:
//  CLK, RESET_N           rising-edge clock, asynchronous active-low reset
//  IN_VALID/IN_READY      upstream handshake; IN_READY is registered except for the BUSYWAIT gate
//  IN_DATA, IN_CTRL       upstream payload and side-effecting control
//  FLUSH                  synchronous discard of every held entry (overrides everything else)
//  BUSYWAIT               global stall: freezes state, blocks both handshakes
//  OUT_VALID/OUT_READY    downstream handshake
//  OUT_DATA, OUT_CTRL     main-slot contents; OUT_CTRL is CTRL_BUBBLE whenever OUT_VALID=0
// The main slot drives the outputs directly; the skid slot catches the one entry accepted
// while the downstream is not taking, which is what allows a registered IN_READY at full rate.
module pipe_stage_skid_reg
  import pipe_stage_skid_reg_pkg::*;
#(
  parameter int                    DATA_WIDTH  = 133,
  parameter int                    CTRL_WIDTH  = 8,
  parameter logic [CTRL_WIDTH-1:0] CTRL_BUBBLE = '0
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  input  logic                  IN_VALID,
  output logic                  IN_READY,
  input  logic [DATA_WIDTH-1:0] IN_DATA,
  input  logic [CTRL_WIDTH-1:0] IN_CTRL,
  input  logic                  FLUSH,
  input  logic                  BUSYWAIT,
  output logic                  OUT_VALID,
  input  logic                  OUT_READY,
  output logic [DATA_WIDTH-1:0] OUT_DATA,
  output logic [CTRL_WIDTH-1:0] OUT_CTRL
);

  state_t                state_q;
  state_t                state_d;
  logic                  main_vld;
  logic                  skid_vld;
  logic [DATA_WIDTH-1:0] skid_data;
  logic [CTRL_WIDTH-1:0] skid_ctrl;
  logic                  main_load;
  logic                  main_clr;
  logic                  main_from_skid;
  logic                  skid_load;
  logic                  skid_clr;
  logic [DATA_WIDTH-1:0] main_d_data;
  logic [CTRL_WIDTH-1:0] main_d_ctrl;
  logic                  accept;
  logic                  deliver;

  // BUSYWAIT is the only combinational contributor to IN_READY.
  assign IN_READY  = !skid_vld && !BUSYWAIT;
  assign accept    = IN_VALID && IN_READY;
  assign deliver   = main_vld && OUT_READY && !BUSYWAIT;
  assign OUT_VALID = main_vld;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    main_load      = 1'b0;
    main_clr       = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    skid_clr       = 1'b0;
    if (FLUSH) begin
      main_clr = 1'b1;
      skid_clr = 1'b1;
      state_d  = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            main_load = 1'b1;
            state_d   = ST_HALF;
          end
        end
        ST_HALF: begin
          if (accept && deliver) begin
            main_load = 1'b1;
          end else if (accept) begin
            skid_load = 1'b1;
            state_d   = ST_FULL;
          end else if (deliver) begin
            main_clr = 1'b1;
            state_d  = ST_EMPTY;
          end
        end
        ST_FULL: begin
          // IN_READY is low here, so only the skid entry can move forward.
          if (deliver) begin
            main_load      = 1'b1;
            main_from_skid = 1'b1;
            skid_clr       = 1'b1;
            state_d        = ST_HALF;
          end
        end
        default: begin
          state_d = ST_EMPTY;
        end
      endcase
    end
  end

  assign main_d_data = main_from_skid ? skid_data : IN_DATA;
  assign main_d_ctrl = main_from_skid ? skid_ctrl : IN_CTRL;

  pipe_stage_skid_reg_slot #(
    .DATA_WIDTH (DATA_WIDTH),
    .CTRL_WIDTH (CTRL_WIDTH),
    .CTRL_BUBBLE(CTRL_BUBBLE)
  ) u_main (
    .clk   (CLK),
    .rst_n (RESET_N),
    .load  (main_load),
    .clear (main_clr),
    .d_data(main_d_data),
    .d_ctrl(main_d_ctrl),
    .vld   (main_vld),
    .q_data(OUT_DATA),
    .q_ctrl(OUT_CTRL)
  );

  pipe_stage_skid_reg_slot #(
    .DATA_WIDTH (DATA_WIDTH),
    .CTRL_WIDTH (CTRL_WIDTH),
    .CTRL_BUBBLE(CTRL_BUBBLE)
  ) u_skid (
    .clk   (CLK),
    .rst_n (RESET_N),
    .load  (skid_load),
    .clear (skid_clr),
    .d_data(IN_DATA),
    .d_ctrl(IN_CTRL),
    .vld   (skid_vld),
    .q_data(skid_data),
    .q_ctrl(skid_ctrl)
  );

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// Bench for pipe_stage_skid_reg: directed scenarios followed by random traffic, every
// cycle compared against a queue-based model of a 2-deep FIFO register.
module tb_pipe_stage_skid_reg;

  localparam int DW = 133;
  localparam int CW = 8;

  logic          CLK;
  logic          RESET_N;
  logic          IN_VALID;
  logic          IN_READY;
  logic [DW-1:0] IN_DATA;
  logic [CW-1:0] IN_CTRL;
  logic          FLUSH;
  logic          BUSYWAIT;
  logic          OUT_VALID;
  logic          OUT_READY;
  logic [DW-1:0] OUT_DATA;
  logic [CW-1:0] OUT_CTRL;

  pipe_stage_skid_reg #(
    .DATA_WIDTH (DW),
    .CTRL_WIDTH (CW),
    .CTRL_BUBBLE(8'h00)
  ) dut (
    .CLK      (CLK),
    .RESET_N  (RESET_N),
    .IN_VALID (IN_VALID),
    .IN_READY (IN_READY),
    .IN_DATA  (IN_DATA),
    .IN_CTRL  (IN_CTRL),
    .FLUSH    (FLUSH),
    .BUSYWAIT (BUSYWAIT),
    .OUT_VALID(OUT_VALID),
    .OUT_READY(OUT_READY),
    .OUT_DATA (OUT_DATA),
    .OUT_CTRL (OUT_CTRL)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [CW-1:0] c;
  } ent_t;

  ent_t          mq[$];
  logic [DW-1:0] m_last;
  int            nvec;
  int            nerr;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    nvec++;
    assert (obs === exp)
    else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_last = '0;
  endtask

  task automatic check_outs();
    logic          exp_vld;
    logic [CW-1:0] exp_ctrl;
    exp_vld  = (mq.size() > 0);
    exp_ctrl = exp_vld ? mq[0].c : 8'h00;
    chk("out_valid", DW'(OUT_VALID), DW'(exp_vld));
    chk("out_data", OUT_DATA, m_last);
    chk("out_ctrl", DW'(OUT_CTRL), DW'(exp_ctrl));
  endtask

  // One clock: drive inputs, check IN_READY before the edge, advance model, check outputs.
  task automatic step(input logic iv, input logic [DW-1:0] id, input logic [CW-1:0] ic,
                      input logic ordy, input logic fl, input logic bw);
    logic acc;
    logic dlv;
    ent_t e;
    IN_VALID  = iv;
    IN_DATA   = id;
    IN_CTRL   = ic;
    OUT_READY = ordy;
    FLUSH     = fl;
    BUSYWAIT  = bw;
    #1;
    chk("in_ready", DW'(IN_READY), DW'((mq.size() < 2) && !bw));
    acc = iv && (mq.size() < 2) && !bw;
    dlv = (mq.size() > 0) && ordy && !bw;
    @(posedge CLK);
    if (fl) begin
      mq.delete();
    end else begin
      if (dlv) void'(mq.pop_front());
      if (acc) begin
        e.d = id;
        e.c = ic;
        mq.push_back(e);
      end
    end
    if (mq.size() > 0) m_last = mq[0].d;
    #1;
    check_outs();
  endtask

  function automatic logic [DW-1:0] rand_data();
    logic [159:0] r;
    r = {$urandom, $urandom, $urandom, $urandom, $urandom};
    return r[DW-1:0];
  endfunction

  initial begin
    logic          r_iv;
    logic          r_ordy;
    logic          r_fl;
    logic          r_bw;
    logic [CW-1:0] r_c;
    nvec      = 0;
    nerr      = 0;
    IN_VALID  = 1'b0;
    IN_DATA   = '0;
    IN_CTRL   = '0;
    FLUSH     = 1'b0;
    BUSYWAIT  = 1'b0;
    OUT_READY = 1'b0;
    RESET_N   = 1'b1;
    model_reset();

    // Reset state
    #1 RESET_N = 1'b0;
    #1;
    chk("rst_out_valid", DW'(OUT_VALID), '0);
    chk("rst_out_ctrl", DW'(OUT_CTRL), '0);
    chk("rst_out_data", OUT_DATA, '0);
    chk("rst_in_ready", DW'(IN_READY), DW'(1'b1));
    @(negedge CLK);
    RESET_N = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);

    // Streaming at one entry per cycle
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, DW'(i), CW'(i), 1'b1, 1'b0, 1'b0);
      chk("stream_data", OUT_DATA, DW'(i));
    end
    step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);

    // Back-pressure fills the skid, nothing lost
    step(1'b1, DW'(8'hA), 8'h1A, 1'b0, 1'b0, 1'b0);
    step(1'b1, DW'(8'hB), 8'h1B, 1'b0, 1'b0, 1'b0);
    chk("full_in_ready", DW'(IN_READY), '0);
    step(1'b1, DW'(8'hC), 8'h1C, 1'b0, 1'b0, 1'b0);
    chk("bp_hold_a", OUT_DATA, DW'(8'hA));
    step(1'b1, DW'(8'hC), 8'h1C, 1'b1, 1'b0, 1'b0);
    chk("bp_b", OUT_DATA, DW'(8'hB));
    step(1'b1, DW'(8'hC), 8'h1C, 1'b1, 1'b0, 1'b0);
    chk("bp_c", OUT_DATA, DW'(8'hC));
    step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    chk("bp_drained", DW'(OUT_VALID), '0);

    // Flush from FULL discards held and offered entries
    step(1'b1, DW'(8'h11), 8'h05, 1'b0, 1'b0, 1'b0);
    step(1'b1, DW'(8'h12), 8'h05, 1'b0, 1'b0, 1'b0);
    step(1'b1, DW'(8'hD), 8'h07, 1'b0, 1'b1, 1'b0);
    chk("flush_valid", DW'(OUT_VALID), '0);
    chk("flush_ctrl", DW'(OUT_CTRL), '0);
    chk("flush_data_held", OUT_DATA, DW'(8'h11));
    chk("flush_in_ready", DW'(IN_READY), DW'(1'b1));
    step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    chk("flush_no_d", DW'(OUT_VALID), '0);

    // BUSYWAIT freezes a HALF register
    step(1'b1, DW'(8'h3), 8'h33, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, DW'(8'h4), 8'h44, 1'b1, 1'b0, 1'b1);
      chk("bw_data_held", OUT_DATA, DW'(8'h3));
      chk("bw_in_ready", DW'(IN_READY), '0);
    end
    step(1'b1, DW'(8'h4), 8'h44, 1'b1, 1'b0, 1'b0);
    chk("bw_release_next", OUT_DATA, DW'(8'h4));
    step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);

    // Asynchronous reset off the clock edge while FULL
    step(1'b1, DW'(8'h21), 8'h5A, 1'b0, 1'b0, 1'b0);
    step(1'b1, DW'(8'h22), 8'h5B, 1'b0, 1'b0, 1'b0);
    #2 RESET_N = 1'b0;
    #1;
    chk("arst_valid", DW'(OUT_VALID), '0);
    chk("arst_data", OUT_DATA, '0);
    chk("arst_ctrl", DW'(OUT_CTRL), '0);
    chk("arst_in_ready", DW'(IN_READY), DW'(1'b1));
    model_reset();
    @(negedge CLK);
    RESET_N = 1'b1;

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      r_iv   = 1'($urandom_range(0, 1));
      r_ordy = ($urandom_range(0, 3) != 0);
      r_fl   = ($urandom_range(0, 15) == 0);
      r_bw   = ($urandom_range(0, 7) == 0);
      r_c    = CW'($urandom);
      step(r_iv, rand_data(), r_c, r_ordy, r_fl, r_bw);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
